// File: rtl/mod_sub_sched_pkg.sv
// Shared definitions for the ModSub scheduler.
// Holds the default configuration and the canonical tag / result-entry layouts
// for that configuration. Modules parameterised away from the defaults build
// their own equivalently shaped types from their parameters.
package mod_sub_sched_pkg;

    localparam int K_DEF     = 54;
    localparam int NREQ_DEF  = 4;
    localparam int DEPTH_DEF = 4;
    localparam int ID_W      = $clog2(NREQ_DEF);

    // One stage of the tag pipe that shadows the ModSub datapath.
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    // One result FIFO entry: requester ID plus (a - b) mod q.
    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [K_DEF-1:0] data;
    } res_entry_t;

endpackage

// File: rtl/mod_sub.sv
// ModSub: 2-cycle modular subtractor, out = (a - b) mod q.
// No stall and no reset: a result appears exactly two cycles after its
// operands, so whoever drives it has to track validity separately.
// Ports:
//   clk    clock
//   q      modulus (held stable while operations are in flight)
//   a, b   operands, both expected to be < q
//   out    (a - b) mod q, two cycles after a/b were presented
module mod_sub #(
    parameter int K = 54
) (
    input  logic         clk,
    input  logic [K-1:0] q,
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    output logic [K-1:0] out
);

    // Extra MSB holds the borrow of a - b.
    logic [K:0]   diff_reg;
    logic [K-1:0] out_reg;

    always_ff @(posedge clk) begin
        diff_reg <= {1'b0, a} - {1'b0, b};
        // On borrow the low K bits equal a - b + 2^K; adding q modulo 2^K
        // yields a - b + q, which is the wanted residue.
        out_reg  <= diff_reg[K] ? (diff_reg[K-1:0] + q) : diff_reg[K-1:0];
    end

    assign out = out_reg;

endmodule

// File: rtl/mod_sub_result_fifo.sv
// Result FIFO for the ModSub scheduler.
// Small first-word-fall-through queue: the head entry is visible on rdata
// whenever empty is low. Registered count and pointers, async reset.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, wdata   write one entry (caller guarantees space)
//   pop           remove head entry (ignored while empty)
//   rdata         head entry
//   full, empty   occupancy flags
//   count         number of stored entries
module mod_sub_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          pop_eff;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign count   = count_reg;
    assign pop_eff = pop & ~empty;
    assign rdata   = mem[rd_ptr_reg];

    // Storage carries no reset; validity is tracked by count and pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop_eff) begin
                rd_ptr_reg <= (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({push, pop_eff})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // The issuing side reserves a slot before it starts an operation, so a
    // push into a full queue means the credit accounting is broken.
    assert property (@(posedge clk) disable iff (rst) (push |-> !full));

endmodule

// File: rtl/mod_sub_scheduler.sv
// Round-robin scheduler sharing one ModSub between NREQ requesters.
// A request is granted only when a result slot is guaranteed (credits =
// queued results + operations still inside ModSub), because ModSub cannot
// stall. Each issued operation carries its requester ID through a 2-stage
// tag pipe aligned with ModSub, and lands in the result FIFO together with
// the difference.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   q           modulus
//   req_valid   per-requester operation valid
//   req_a/req_b packed operands, slice i belongs to requester i
//   req_ready   one-hot grant (handshake = req_valid[i] & req_ready[i])
//   res_valid   result available at FIFO head
//   res_ready   consumer accepts head
//   res_id      requester of head result (0 when res_valid is low)
//   res_data    (a - b) mod q of head (0 when res_valid is low)
//   idle        nothing in flight and nothing queued
module mod_sub_scheduler
    import mod_sub_sched_pkg::*;
#(
    parameter int K     = K_DEF,
    parameter int NREQ  = NREQ_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [K-1:0]            q,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*K-1:0]       req_a,
    input  logic [NREQ*K-1:0]       req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [$clog2(NREQ)-1:0] res_id,
    output logic [K-1:0]            res_data,
    output logic                    idle
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
    } sched_tag_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [K-1:0]   data;
    } sched_entry_t;

    // Reset asserts asynchronously everywhere but is released only after
    // two clean clock edges, so every flop leaves reset on the same edge.
    logic [1:0] rst_pipe_reg;
    logic       rst_int;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_pipe_reg <= 2'b11;
        end else begin
            rst_pipe_reg <= {rst_pipe_reg[0], 1'b0};
        end
    end

    assign rst_int = rst_pipe_reg[1];

    // Unpack the per-requester operand slices.
    logic [K-1:0] a_arr [NREQ];
    logic [K-1:0] b_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*K +: K];
            assign b_arr[gi] = req_b[gi*K +: K];
        end
    endgenerate

    logic [IDW-1:0] rr_ptr_reg;
    sched_tag_t     tag1_reg;
    sched_tag_t     tag2_reg;
    logic [1:0]     inflight;
    logic [CW-1:0]  fifo_count;
    logic           can_issue;
    logic           gnt_any;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] cand;

    assign inflight = {1'b0, tag1_reg.valid} + {1'b0, tag2_reg.valid};

    // Uses the registered FIFO count: a pop in this cycle only frees its
    // slot from the next cycle on, which keeps this path short.
    assign can_issue = (int'(fifo_count) + int'(inflight)) < DEPTH;

    // Round-robin search starting at rr_ptr; first valid requester wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        if (can_issue && !rst_int) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = IDW'((int'(rr_ptr_reg) + k) % NREQ);
                if (!gnt_any && req_valid[cand]) begin
                    gnt_any = 1'b1;
                    gnt_id  = cand;
                end
            end
        end
    end

    assign req_ready = gnt_any ? (NREQ'(1) << gnt_id) : '0;

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            rr_ptr_reg <= '0;
            tag1_reg   <= '0;
            tag2_reg   <= '0;
        end else begin
            if (gnt_any) begin
                rr_ptr_reg <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
            end
            tag1_reg.valid <= gnt_any;
            tag1_reg.id    <= gnt_id;
            tag2_reg       <= tag1_reg;
        end
    end

    // Granted operands feed ModSub directly; with no grant the slice of
    // requester 0 is presented but its result is dropped (no tag).
    logic [K-1:0] ms_out;

    mod_sub #(
        .K (K)
    ) u_mod_sub (
        .clk (clk),
        .q   (q),
        .a   (a_arr[gnt_id]),
        .b   (b_arr[gnt_id]),
        .out (ms_out)
    );

    sched_entry_t wr_entry;
    sched_entry_t head_entry;
    logic         fifo_full;
    logic         fifo_empty;

    assign wr_entry.id   = tag2_reg.id;
    assign wr_entry.data = ms_out;

    mod_sub_result_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(sched_entry_t)),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst_int),
        .push  (tag2_reg.valid),
        .wdata (wr_entry),
        .pop   (res_valid & res_ready),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign res_valid = ~fifo_empty;
    assign res_id    = res_valid ? head_entry.id   : '0;
    assign res_data  = res_valid ? head_entry.data : '0;
    assign idle      = (inflight == 2'd0) && (fifo_count == '0);

endmodule

// File: tb/tb_mod_sub_scheduler.sv
// Self-checking bench for mod_sub_scheduler: directed scenarios followed by
// a randomized phase. Expected results are queued at acceptance time by an
// acceptance monitor and compared by an independent result monitor.
module tb_mod_sub_scheduler;

    localparam int K     = 54;
    localparam int NREQ  = 4;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [K-1:0]      q;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*K-1:0] req_a;
    logic [NREQ*K-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              res_valid;
    logic              res_ready;
    logic [1:0]        res_id;
    logic [K-1:0]      res_data;
    logic              idle;

    mod_sub_scheduler #(.K(K), .NREQ(NREQ), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .q         (q),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_data  (res_data),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned     id;
        longint unsigned data;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          model_rst = 1'b1;
    int unsigned rr_m = 0;
    int          acc_cnt = 0;
    int          pop_cnt = 0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // (a - b) mod q with a, b < q, from plain integer arithmetic.
    function automatic longint unsigned ref_sub(input longint unsigned a, input longint unsigned b,
                                                input longint unsigned m);
        return (a + m - b) % m;
    endfunction

    // Acceptance monitor: predicts the grant from round-robin order and the
    // number of results owed (accepted minus consumed, as of the last edge),
    // and queues the expected result of every handshake.
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_g;
        logic [NREQ-1:0] hs;
        int unsigned     cnd;
        exp_g = '0;
        hs    = req_ready & req_valid;
        if (model_rst) begin
            acc_cnt = 0;
            pop_cnt = 0;
            rr_m    = 0;
            chk("ready_in_reset", req_ready, 0);
        end else begin
            if ((acc_cnt - pop_cnt) < DEPTH) begin
                for (int k = 0; k < NREQ; k++) begin
                    cnd = (rr_m + k) % NREQ;
                    if (exp_g == '0 && req_valid[cnd]) exp_g[cnd] = 1'b1;
                end
            end
            chk("grant", req_ready, exp_g);
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i]) begin
                    exp_t e;
                    e.id   = i;
                    e.data = ref_sub(longint'(req_a[i*K +: K]), longint'(req_b[i*K +: K]), longint'(q));
                    exp_q.push_back(e);
                    $display("accept id=%0d a=%0d b=%0d exp=%0d", i, req_a[i*K +: K], req_b[i*K +: K], e.data);
                    acc_cnt++;
                    rr_m = (i + 1) % NREQ;
                end
            end
            if (res_valid && res_ready) pop_cnt++;
        end
    end

    // Result monitor: pops the scoreboard on every consumed result.
    always @(negedge clk) begin
        exp_t e;
        if (model_rst) begin
            exp_q.delete();
            chk("no_result_in_reset", res_valid, 0);
        end else if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: id=%0d data=%0d, expected none", res_id, res_data);
            end else begin
                e = exp_q.pop_front();
                $display("result id=%0d data=%0d exp_id=%0d exp_data=%0d", res_id, res_data, e.id, e.data);
                chk("res_id", res_id, e.id);
                chk("res_data", res_data, e.data);
            end
        end else if (!res_valid) begin
            chk("res_zero_when_invalid", {res_id, res_data}, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input longint unsigned a, input longint unsigned b);
        req_a[i*K +: K] = a[K-1:0];
        req_b[i*K +: K] = b[K-1:0];
    endtask

    function automatic longint unsigned rnd_below(input longint unsigned m);
        longint unsigned r;
        r = {$urandom, $urandom};
        return r % m;
    endfunction

    task automatic issue_one(input int i, input longint unsigned a, input longint unsigned b);
        int n;
        tick();
        set_ops(i, a, b);
        req_valid    = '0;
        req_valid[i] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready[i] && n < 20) begin
            tick();
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("issue_timeout", 0, 1);
        tick();
        req_valid = '0;
    endtask

    task automatic expect_one(input int id, input longint unsigned data);
        int n;
        n = 0;
        @(negedge clk);
        while (!(res_valid && res_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            chk("result_timeout", 0, 1);
        end else begin
            chk("direct_id", res_id, id);
            chk("direct_data", res_data, data);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!idle && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", idle, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int              acc;
        int              pop_cyc;
        int              acc_cyc;
        longint unsigned tmp;

        rst       = 1'b1;
        model_rst = 1'b1;
        q         = 54'd97;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;

        // Reset state, with requests pending to show they are ignored.
        repeat (2) tick();
        req_valid = '1;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_idle", idle, 1);
        req_valid = '0;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        model_rst = 1'b0;

        // Single op with wrap: 5 - 10 mod 97 = 92, 3-cycle latency.
        res_ready = 1'b1;
        set_ops(0, 5, 10);
        req_valid = 4'b0001;
        @(negedge clk);
        chk("t1_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk("t1_not_yet_valid", res_valid, 0);
        @(negedge clk);
        chk("t1_valid_t3", res_valid, 1);
        chk("t1_id", res_id, 0);
        chk("t1_data", res_data, 92);
        chk("t1_not_idle", idle, 0);
        @(negedge clk);
        chk("t1_idle_t4", idle, 1);

        // No wrap.
        issue_one(2, 50, 8);
        expect_one(2, 42);
        wait_idle();

        // Round-robin with everyone asking: one accept per cycle.
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            req_valid = '1;
            for (int i = 0; i < NREQ; i++) set_ops(i, rnd_below(97), rnd_below(97));
            @(negedge clk);
            if (req_ready != '0) acc++;
        end
        chk("rr_accepts", acc, 20);
        tick();
        req_valid = '0;
        wait_idle();

        // Backpressure: only DEPTH accepts with the consumer stalled.
        acc = 0;
        tick();
        res_ready = 1'b0;
        req_valid = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            set_ops(0, rnd_below(97), rnd_below(97));
            @(negedge clk);
            if (req_ready[0]) acc++;
            if (c == 9) chk("bp_stalled_ready", req_ready, 0);
            tick();
        end
        chk("bp_accepts", acc, 4);
        res_ready = 1'b1;
        pop_cyc = -1;
        acc_cyc = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (res_valid && res_ready && pop_cyc < 0) pop_cyc = c;
            if (req_ready[0] && acc_cyc < 0) acc_cyc = c;
            tick();
            set_ops(0, rnd_below(97), rnd_below(97));
        end
        chk("bp_resume_after_pop", acc_cyc, pop_cyc + 1);
        req_valid = '0;
        wait_idle();

        // Fairness after skip: pointer at 1, requesters 3 and 0 pending.
        issue_one(0, 7, 3);
        wait_idle();
        tick();
        set_ops(3, 20, 30);
        set_ops(0, 60, 1);
        req_valid = 4'b1001;
        @(negedge clk);
        chk("fair_first_req3", req_ready, 4'b1000);
        tick();
        req_valid = 4'b0001;
        @(negedge clk);
        chk("fair_then_req0", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        wait_idle();

        // Reset with one result queued and two operations inside ModSub.
        tick();
        res_ready = 1'b0;
        issue_one(1, 30, 40);
        tick();
        tick();
        set_ops(0, 11, 22);
        set_ops(1, 33, 44);
        req_valid = 4'b0011;
        acc = 0;
        @(negedge clk);
        if (req_ready != '0) acc++;
        tick();
        @(negedge clk);
        if (req_ready != '0) acc++;
        chk("mid_two_accepts", acc, 2);
        tick();
        rst       = 1'b1;
        model_rst = 1'b1;
        req_valid = '0;
        #1;
        chk("mid_res_valid", res_valid, 0);
        chk("mid_idle", idle, 1);
        chk("mid_req_ready", req_ready, 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (4) tick();
        model_rst = 1'b0;
        res_ready = 1'b1;
        repeat (6) tick();
        chk("mid_idle_after", idle, 1);
        issue_one(2, 50, 8);
        expect_one(2, 42);
        wait_idle();

        // Randomized traffic with a wide modulus.
        tmp = {$urandom, $urandom};
        q   = tmp[K-1:0] | (54'd1 << (K - 1));
        for (int c = 0; c < 400; c++) begin
            tick();
            req_valid = NREQ'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) set_ops(i, rnd_below(longint'(q)), rnd_below(longint'(q)));
        end
        tick();
        req_valid = '0;
        res_ready = 1'b1;
        wait_idle();
        @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_sub_scheduler.md
Name: mod_sub_scheduler

Overview:
- Shares one 2-cycle modular subtractor (ModSub, out = (a - b) mod q) between NREQ requesters using round-robin arbitration.
- Each accepted operation is tagged with its requester ID. Results land in a small output FIFO with ready/valid backpressure.
- Issue is credit-gated, because ModSub has no stall input.
- Sits between the NTT/key-switching operand sequencers and the shared ModSub instance.

Parameters:
- K, 54, operand/modulus width
- NREQ, 4, number of requesters (>=2)
- DEPTH, 4, result FIFO entries (>=4 for sustained 1 op/cc)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- q  in  K  modulus; stable while any op is in flight or queued
- req_valid  in  NREQ  per-requester operation valid
- req_a  in  NREQ*K  packed minuends; slice i belongs to requester i
- req_b  in  NREQ*K  packed subtrahends
- req_ready  out  NREQ  one-hot grant; handshake = req_valid[i] & req_ready[i]
- res_valid  out  1  FIFO head valid
- res_ready  in  1  consumer accepts head
- res_id  out  $clog2(NREQ)  requester ID of head result
- res_data  out  K  (a - b) mod q of head
- idle  out  1  no op in flight and FIFO empty

Behaviour:
- Reset (async assert, sync deassert internally):
  - rr_ptr=0; tag pipe invalid; FIFO empty (count=0, rd/wr ptr=0).
  - req_ready=0, res_valid=0, idle=1.
  - res_id and res_data are forced to 0 whenever res_valid=0.
- Credit rule: can_issue = (fifo_count + inflight) < DEPTH.
  - inflight = number of valid tag stages (0..2).
  - fifo_count is the registered value. A pop in the current cycle frees its credit only from the next cycle (conservative).
- Arbitration, combinational:
  - If can_issue, grant the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … mod NREQ.
  - req_ready is one-hot on the granted index, otherwise all zero.
  - req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
- On handshake at cycle t:
  - The granted req_a/req_b slices drive ModSub unbuffered in cycle t.
  - Tag {valid=1, id} enters a 2-stage shift register aligned to ModSub latency.
  - rr_ptr <= (id+1) mod NREQ. With no handshake, rr_ptr holds.
- Cycle t+2: ModSub out plus tag stage 2 are written to the FIFO. res_valid rises at t+3 at the earliest (3cc accept-to-result when the FIFO is empty).
- FIFO behaviour:
  - Pop when res_valid & res_ready.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap mod DEPTH.
  - Push is never blocked; the credit rule guarantees space. Push while full is an assertion failure.
- Ordering: results exit in global issue order. Per-requester order is preserved.
- Arithmetic:
  - Operands must satisfy a, b < q.
  - Result is a-b if a>=b, else a-b+q, always < q.
  - No check is made on out-of-range inputs.
- Reset mid-operation: in-flight ModSub data is discarded because its tags are cleared, and queued results are lost. ModSub itself is not reset.
- idle = (inflight==0) & (fifo_count==0), registered-state derived.
- A change of q while !idle is undefined.

Decomposition:
- Package mod_sub_sched_pkg:
  - localparam ID_W = $clog2(NREQ)
  - typedef struct packed {logic valid; logic [ID_W-1:0] id;} tag_t
  - typedef struct packed {logic [ID_W-1:0] id; logic [K-1:0] data;} res_entry_t (parameterised via K in the package or by a module-level typedef)
- Sub-module mod_sub_result_fifo (DEPTH, entry width):
  - registered count, full/empty flags, async reset.
- Top level: arbiter, credit logic and tag pipe, with an existing ModSub instance.

Test Plan:
- Single op, q=97: req0 a=5 b=10 → accepted cycle t; res_valid at t+3 with res_id=0, res_data=92; idle returns to 1 at t+4 after pop.
- No wrap, q=97: req2 a=50 b=8 → res_data=42, res_id=2.
- Round-robin: all 4 requesters valid continuously, res_ready=1 → grants 0,1,2,3,0,… one per cycle; results in that ID order, no bubbles after fill.
- Backpressure: res_ready=0, req0 valid 10 cycles → exactly 4 accepted, then req_ready=0. Raising res_ready drains 4 results, and issue resumes the cycle after the first pop.
- Fairness after skip: rr_ptr=1, only req3 and req0 valid → req3 granted first, then req0.
- Reset mid-flight: assert rst one cycle after accepting 2 ops with 1 queued → res_valid=0 and idle=1 immediately; no stale result appears after deassert; the next op returns the correct value.
